// File: rtl/coprocessor_mdu_datapath_if.sv
// Stage-enable bus between the MDU sequencing FSM (master) and the
// iterative multiply/divide datapath (slave).
interface coprocessor_mdu_datapath_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stage_setup_en;
  logic                  stage_compute_en;
  logic                  stage_normalize_en;
  logic                  stage_complete_en;
  logic [2:0]            mdu_operation;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [4:0]            required_cycles;
  logic                  divide_by_zero;
  logic                  overflow_detected;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;
  logic                  exc_result_valid;

  modport master (
    output stage_setup_en, stage_compute_en, stage_normalize_en, stage_complete_en,
    output mdu_operation, op_a, op_b,
    input  required_cycles, divide_by_zero, overflow_detected,
    input  result, result_valid, exc_result_valid
  );

  modport slave (
    input  stage_setup_en, stage_compute_en, stage_normalize_en, stage_complete_en,
    input  mdu_operation, op_a, op_b,
    output required_cycles, divide_by_zero, overflow_detected,
    output result, result_valid, exc_result_valid
  );
endinterface

// File: rtl/coprocessor_mdu_datapath.sv
// Radix-4 iterative RV32M multiply/divide datapath driven by stage enables
// from the MDU sequencer; two radix-2 steps per compute cycle.
module coprocessor_mdu_datapath #(
  parameter int DATA_WIDTH = 32
) (
  input logic                        clk,
  input logic                        rst,
  coprocessor_mdu_datapath_if.slave  bus
);
  localparam int         W     = DATA_WIDTH;
  localparam logic [4:0] ITERS = 5'(W / 2);

  logic [2:0]     op;
  logic           a_signed, b_signed, a_neg, b_neg, neg_setup;
  logic [W-1:0]   a_mag, b_mag, smin, exc_val;
  logic           dbz, ovf, exc;

  logic [2:0]     op_q;
  logic           neg_res;
  logic [W-1:0]   a_reg, b_reg, rem, result_q;
  logic [2*W-1:0] acc;
  logic [4:0]     step;
  logic           exc_flag, exc_vld;

  logic [2*W-1:0] acc_n, prod_c;
  logic [W-1:0]   a_n, b_n, rem_n, quo_c, rem_c, norm_val;
  logic [W:0]     r, diff, sum;

  assign op       = bus.mdu_operation;
  assign smin     = {1'b1, {(W-1){1'b0}}};
  // Unsigned operands: MULHU, DIVU, REMU for a; MULHSU additionally for b.
  assign a_signed = (op != 3'b010) && (op != 3'b101) && (op != 3'b111);
  assign b_signed = a_signed && (op != 3'b011);
  assign a_neg    = a_signed & bus.op_a[W-1];
  assign b_neg    = b_signed & bus.op_b[W-1];
  assign a_mag    = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag    = b_neg ? -bus.op_b : bus.op_b;

  always_comb begin
    neg_setup = 1'b0;
    case (op)
      3'b100:  neg_setup = a_neg ^ b_neg;
      3'b110:  neg_setup = a_neg;
      3'b101,
      3'b111:  neg_setup = 1'b0;
      default: neg_setup = a_neg ^ b_neg;
    endcase
  end

  assign dbz = bus.stage_setup_en & op[2] & (bus.op_b == '0);
  assign ovf = bus.stage_setup_en & op[2] & ~op[0] & (bus.op_a == smin) & (&bus.op_b);
  assign exc = dbz | ovf;
  // REM family returns the dividend on /0 and zero on overflow; DIV family
  // returns all-ones on /0 and the dividend (signed-min) on overflow.
  assign exc_val = op[1] ? (dbz ? bus.op_a : '0) : (dbz ? '1 : bus.op_a);

  always_comb begin
    acc_n = acc;
    a_n   = a_reg;
    b_n   = b_reg;
    rem_n = rem;
    r     = '0;
    diff  = '0;
    sum   = '0;
    for (int i = 0; i < 2; i++) begin
      if (op_q[2]) begin
        // Restoring step: a_reg shifts out dividend bits and in quotient bits.
        r    = {rem_n, a_n[W-1]};
        a_n  = {a_n[W-2:0], 1'b0};
        diff = r - {1'b0, b_n};
        if (!diff[W]) begin
          rem_n  = diff[W-1:0];
          a_n[0] = 1'b1;
        end else begin
          rem_n = r[W-1:0];
        end
      end else begin
        sum   = {1'b0, acc_n[2*W-1:W]} + (b_n[0] ? {1'b0, a_reg} : '0);
        acc_n = {sum, acc_n[W-1:1]};
        b_n   = b_n >> 1;
      end
    end
  end

  assign prod_c = neg_res ? -acc : acc;
  assign quo_c  = neg_res ? -a_reg : a_reg;
  assign rem_c  = neg_res ? -rem : rem;

  always_comb begin
    norm_val = rem_c;
    case (op_q)
      3'b000:                norm_val = prod_c[W-1:0];
      3'b001, 3'b010, 3'b011: norm_val = prod_c[2*W-1:W];
      3'b100, 3'b101:        norm_val = quo_c;
      default:               norm_val = rem_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      neg_res  <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      rem      <= '0;
      acc      <= '0;
      step     <= '0;
      exc_flag <= 1'b0;
      exc_vld  <= 1'b0;
      result_q <= '0;
    end else begin
      exc_vld <= 1'b0;
      if (bus.stage_setup_en) begin
        op_q     <= op;
        neg_res  <= neg_setup;
        a_reg    <= a_mag;
        b_reg    <= b_mag;
        rem      <= '0;
        acc      <= '0;
        exc_flag <= exc;
        exc_vld  <= exc;
        step     <= exc ? ITERS : 5'd0;
        if (exc) result_q <= exc_val;
      end else if (bus.stage_compute_en) begin
        if (step < ITERS) begin
          acc  <= acc_n;
          a_reg <= a_n;
          b_reg <= b_n;
          rem  <= rem_n;
          step <= step + 5'd1;
        end
      end else if (bus.stage_normalize_en) begin
        if (!exc_flag) result_q <= norm_val;
      end
    end
  end

  assign bus.required_cycles   = ITERS;
  assign bus.divide_by_zero    = dbz;
  assign bus.overflow_detected = ovf;
  assign bus.result            = result_q;
  assign bus.result_valid      = bus.stage_complete_en & ~exc_flag;
  assign bus.exc_result_valid  = exc_vld;
endmodule

// File: doc/coprocessor_mdu_datapath.md
# coprocessor_mdu_datapath

Iterative multiply/divide datapath. It is the responder side of the MDU stage-enable interface: it executes the setup, compute, normalize and complete stages as the MDU sequencing FSM commands them. It reports `required_cycles` and the setup-time exception flags (`divide_by_zero`, `overflow_detected`) back to that FSM. It produces RISC-V M-extension results: MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM, REMU.

## Interface
- `DATA_WIDTH`, default 32: operand/result width. Must be even, 8..62, so that DATA_WIDTH/2 fits in 5 bits.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stage_setup_en` in 1: capture operands and operation.
- `stage_compute_en` in 1: perform one radix-4 iteration.
- `stage_normalize_en` in 1: sign-correct and select the result field.
- `stage_complete_en` in 1: result hand-off cycle.
- `mdu_operation` in 3: 000 MUL, 001 MULH, 010 MULHU, 011 MULHSU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. Sampled only with setup.
- `op_a` in DATA_WIDTH: multiplicand/dividend, sampled with setup.
- `op_b` in DATA_WIDTH: multiplier/divisor, sampled with setup.
- `required_cycles` out 5: constant DATA_WIDTH/2.
- `divide_by_zero` out 1: combinational; = `stage_setup_en` & `mdu_operation[2]` & (`op_b`==0).
- `overflow_detected` out 1: combinational; = `stage_setup_en` & op∈{DIV,REM} & `op_a`==signed-min & `op_b`==all-ones.
- `result` out DATA_WIDTH: result register.
- `result_valid` out 1: = `stage_complete_en` & !`exc_flag`.
- `exc_result_valid` out 1: registered; high for 1 cycle after a setup that raised an exception.

## Operation
- Reset: `result`=0, `exc_result_valid`=0, `exc_flag`=0, step counter=0, all internal registers=0.
- Under reset, `result_valid`, `divide_by_zero` and `overflow_detected` are 0 provided the enables are 0.
- Enable priority if several are asserted: setup > compute > normalize. `stage_complete_en` has no state effect.

**Setup cycle**
- Latch the operation.
- Latch magnitudes |a| and |b|:
  - signed operand = MUL/MULH/DIV/REM: both a and b; MULHSU: a only.
  - MUL low bits are sign-agnostic; use two's-complement magnitudes anyway.
- Latch `neg_res`:
  - multiply: sign(a) XOR sign(b);
  - DIV: sign(a) XOR sign(b);
  - REM: sign(a).
- Clear the 2W accumulator (multiply) or the remainder (divide). Step counter ← 0. `exc_flag` ← 0.

**Exception setup** (`divide_by_zero` or `overflow_detected` high)
- `result` ← defined value: DIV/DIVU by 0 → all-ones; REM/REMU by 0 → `op_a`; DIV overflow → `op_a` (signed-min); REM overflow → 0.
- `exc_flag` ← 1; `exc_result_valid` pulses next cycle.
- Step counter ← DATA_WIDTH/2, so compute does nothing.

**Compute cycle**
- If step < DATA_WIDTH/2: perform two radix-2 steps, then step+1.
  - Multiply: two shift-add steps on the 2W product, LSB-first on |b|.
  - Divide: two restoring steps; quotient bits shift into the |a| register, remainder is W+1 bits wide.
- If step ≥ DATA_WIDTH/2: hold all state. Extra compute cycles are harmless.

**Normalize cycle** (skipped if `exc_flag`)
- Apply the `neg_res` two's-complement correction to the full 2W product, the quotient, or the remainder.
- `result` ← field selected by operation:
  - low W bits: MUL;
  - high W bits: MULH/MULHU/MULHSU;
  - quotient: DIV/DIVU;
  - remainder: REM/REMU.

**Result hold:** `result` holds until the next setup or reset.

**Boundaries**
- New setup mid-computation: abort and restart with the new operands.
- Reset mid-operation: all state cleared; no `result_valid`.
- Compute or normalize without a prior setup: operates on stale/zero state; no hazard.

## Timing
- Setup cycle = T0.
- Compute cycles T1..T17 (the FSM holds compute for `required_cycles`+1 cycles). Iterations occur on the first 16 compute cycles; the last is idle.
- Normalize at T18; `result` is updated at the end of T18.
- Complete at T19: `result_valid`=1 and `result` stable. Total latency setup→valid = 19 cycles for DATA_WIDTH=32 (DATA_WIDTH/2+3 in general).
- Exception: flags are combinational in T0; `result` is updated at the end of T0; `exc_result_valid`=1 in T1.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), full enable sequence → `result`=0xFFFFFFEB, `result_valid` high only at T19.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 5/0 → `divide_by_zero`=1 in T0, `result`=0xFFFFFFFF and `exc_result_valid`=1 at T1. REMU 5/0 → `result`=5. MUL x/0 → no flag.
- DIV 0x80000000/0xFFFFFFFF → `overflow_detected`=1, `result`=0x80000000. REM → 0. DIVU with the same operands → no flag, `result`=0.
- Assert `rst` at compute step 8, then run MUL 3×5 → `result`=15. Separately, re-issue setup mid-divide → the new operands' result only.
